// File: rtl/display_scanner.sv
// Four-digit multiplexed hex display scanner with frame-synchronous value update
// and optional leading-zero blanking.
module display_scanner #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_en,
  output logic [3:0]  digit_data,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {S_D0, S_D1, S_D2, S_D3} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [CW-1:0] r_cnt;
  logic        w_tick;
  logic        w_frame_end;
  logic [15:0] r_shadow;
  logic [15:0] r_pending;
  logic        r_pend_flag;
  logic        r_blank;
  logic        r_frame_done;
  logic        w_z3;
  logic        w_z2;
  logic        w_z1;

  assign w_tick      = (r_cnt == LAST);
  assign w_frame_end = w_tick && (r_state == S_D3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_D0;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      unique case (r_state)
        S_D0: w_state_next = S_D1;
        S_D1: w_state_next = S_D2;
        S_D2: w_state_next = S_D3;
        S_D3: w_state_next = S_D0;
        default: w_state_next = S_D0;
      endcase
    end
  end

  // A load landing on the boundary tick bypasses pending so the newest value wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow     <= '0;
      r_pending    <= '0;
      r_pend_flag  <= 1'b0;
      r_blank      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_blank      <= blank_en;
      r_frame_done <= w_frame_end;
      if (w_frame_end) begin
        if (load) begin
          r_shadow  <= value_in;
          r_pending <= value_in;
        end else if (r_pend_flag) begin
          r_shadow <= r_pending;
        end
        r_pend_flag <= 1'b0;
      end else if (load) begin
        r_pending   <= value_in;
        r_pend_flag <= 1'b1;
      end
    end
  end

  assign w_z3 = (r_shadow[15:12] == 4'h0);
  assign w_z2 = w_z3 && (r_shadow[11:8] == 4'h0);
  assign w_z1 = w_z2 && (r_shadow[7:4] == 4'h0);

  always_comb begin
    digit_data = r_shadow[3:0];
    digit_sel  = 4'b0001;
    unique case (r_state)
      S_D0: begin
        digit_data = r_shadow[3:0];
        digit_sel  = 4'b0001;
      end
      S_D1: begin
        digit_data = r_shadow[7:4];
        digit_sel  = (r_blank && w_z1) ? 4'b0000 : 4'b0010;
      end
      S_D2: begin
        digit_data = r_shadow[11:8];
        digit_sel  = (r_blank && w_z2) ? 4'b0000 : 4'b0100;
      end
      S_D3: begin
        digit_data = r_shadow[15:12];
        digit_sel  = (r_blank && w_z3) ? 4'b0000 : 4'b1000;
      end
      default: begin
        digit_data = r_shadow[3:0];
        digit_sel  = 4'b0001;
      end
    endcase
  end

  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: DIV=4 instance for scan/tearing/collision/
// blanking, DIV=1 instance for the fast-tick and reset-with-load cases.
module tb_display_scanner;

  logic        clk;
  logic        rst_a, load_a, blank_a;
  logic [15:0] val_a;
  logic [3:0]  data_a, sel_a;
  logic        fd_a;
  logic        rst_b, load_b, blank_b;
  logic [15:0] val_b;
  logic [3:0]  data_b, sel_b;
  logic        fd_b;

  int unsigned n_tests;
  int unsigned n_fail;

  display_scanner #(.DIV(4)) dut_a (
    .clk(clk), .rst(rst_a), .value_in(val_a), .load(load_a), .blank_en(blank_a),
    .digit_data(data_a), .digit_sel(sel_a), .frame_done(fd_a)
  );

  display_scanner #(.DIV(1)) dut_b (
    .clk(clk), .rst(rst_b), .value_in(val_b), .load(load_b), .blank_en(blank_b),
    .digit_data(data_b), .digit_sel(sel_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int unsigned k);
    return v[4*k +: 4];
  endfunction

  function automatic logic [3:0] onehot(input int unsigned k);
    logic [3:0] r;
    r = 4'b0001 << k;
    return r;
  endfunction

  task automatic test_reset();
    int unsigned n;
    rst_a = 1'b1;
    step();
    step();
    rst_a = 1'b0;
    n_tests++;
    if (sel_a !== 4'b0001) begin n_fail++; $display("FAIL reset_sel got %b want 0001", sel_a); end
    n_tests++;
    if (data_a !== 4'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_a); end
    n_tests++;
    if (fd_a !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", fd_a); end
    n = 0;
    while (sel_a === 4'b0001 && n < 20) begin
      step();
      n++;
    end
    n_tests++;
    if (n !== 4) begin n_fail++; $display("FAIL reset_dwell got %0d want 4", n); end
    n_tests++;
    if (sel_a !== 4'b0010) begin n_fail++; $display("FAIL reset_sel2 got %b want 0010", sel_a); end
  endtask

  task automatic test_scan();
    int unsigned n;
    val_a = 16'h1234;
    load_a = 1'b1;
    step();
    load_a = 1'b0;
    n = 0;
    while (fd_a !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_tests++;
    if (fd_a !== 1'b1) begin n_fail++; $display("FAIL scan_wait got fd=%b want 1", fd_a); end
    for (int unsigned j = 0; j < 16; j++) begin
      n_tests++;
      if (data_a !== nib(16'h1234, j/4)) begin
        n_fail++; $display("FAIL scan_data[%0d] got %h want %h", j, data_a, nib(16'h1234, j/4));
      end
      n_tests++;
      if (sel_a !== onehot(j/4)) begin
        n_fail++; $display("FAIL scan_sel[%0d] got %b want %b", j, sel_a, onehot(j/4));
      end
      n_tests++;
      if (fd_a !== (j == 0)) begin
        n_fail++; $display("FAIL scan_fd[%0d] got %b want %b", j, fd_a, (j == 0));
      end
      step();
    end
    n_tests++;
    if (fd_a !== 1'b1) begin n_fail++; $display("FAIL scan_fd_next got %b want 1", fd_a); end
  endtask

  task automatic test_tearing();
    for (int unsigned j = 0; j < 4; j++) step();
    val_a = 16'hABCD;
    load_a = 1'b1;
    step();
    load_a = 1'b0;
    for (int unsigned p = 5; p < 16; p++) begin
      n_tests++;
      if (data_a !== nib(16'h1234, p/4)) begin
        n_fail++; $display("FAIL tear_old[%0d] got %h want %h", p, data_a, nib(16'h1234, p/4));
      end
      step();
    end
    n_tests++;
    if (fd_a !== 1'b1) begin n_fail++; $display("FAIL tear_fd got %b want 1", fd_a); end
    for (int unsigned j = 0; j < 16; j++) begin
      n_tests++;
      if (data_a !== nib(16'hABCD, j/4)) begin
        n_fail++; $display("FAIL tear_new[%0d] got %h want %h", j, data_a, nib(16'hABCD, j/4));
      end
      step();
    end
  endtask

  task automatic test_collision();
    val_a = 16'h5555;
    load_a = 1'b1;
    step();
    load_a = 1'b0;
    for (int unsigned j = 1; j < 15; j++) step();
    val_a = 16'h6666;
    load_a = 1'b1;
    step();
    load_a = 1'b0;
    n_tests++;
    if (fd_a !== 1'b1) begin n_fail++; $display("FAIL coll_fd got %b want 1", fd_a); end
    n_tests++;
    if (dut_a.r_pend_flag !== 1'b0) begin
      n_fail++; $display("FAIL coll_flag got %b want 0", dut_a.r_pend_flag);
    end
    for (int unsigned j = 0; j < 32; j++) begin
      n_tests++;
      if (data_a !== 4'h6) begin
        n_fail++; $display("FAIL coll_data[%0d] got %h want 6", j, data_a);
      end
      step();
    end
  endtask

  task automatic test_blanking();
    val_a = 16'h0070;
    load_a = 1'b1;
    blank_a = 1'b1;
    step();
    load_a = 1'b0;
    for (int unsigned j = 1; j < 16; j++) step();
    for (int unsigned j = 0; j < 16; j++) begin
      logic [3:0] want;
      want = (j < 8) ? onehot(j/4) : 4'b0000;
      n_tests++;
      if (sel_a !== want) begin
        n_fail++; $display("FAIL blank_on_sel[%0d] got %b want %b", j, sel_a, want);
      end
      n_tests++;
      if (data_a !== nib(16'h0070, j/4)) begin
        n_fail++; $display("FAIL blank_on_data[%0d] got %h want %h", j, data_a, nib(16'h0070, j/4));
      end
      step();
    end
    blank_a = 1'b0;
    step();
    for (int unsigned p = 1; p < 16; p++) begin
      n_tests++;
      if (sel_a !== onehot(p/4)) begin
        n_fail++; $display("FAIL blank_off_sel[%0d] got %b want %b", p, sel_a, onehot(p/4));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    n_tests++;
    if (sel_b !== 4'b0001 || fd_b !== 1'b0) begin
      n_fail++; $display("FAIL fast_reset got sel=%b fd=%b want 0001/0", sel_b, fd_b);
    end
    for (int unsigned k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (sel_b !== onehot(k % 4)) begin
        n_fail++; $display("FAIL fast_sel[%0d] got %b want %b", k, sel_b, onehot(k % 4));
      end
      n_tests++;
      if (fd_b !== ((k % 4) == 0)) begin
        n_fail++; $display("FAIL fast_fd[%0d] got %b want %b", k, fd_b, ((k % 4) == 0));
      end
    end
    val_b = 16'h9999;
    load_b = 1'b1;
    rst_b = 1'b1;
    step();
    load_b = 1'b0;
    rst_b = 1'b0;
    n_tests++;
    if (dut_b.r_shadow !== 16'h0000) begin
      n_fail++; $display("FAIL rstload_shadow got %h want 0000", dut_b.r_shadow);
    end
    for (int unsigned k = 0; k < 8; k++) begin
      n_tests++;
      if (data_b !== 4'h0) begin
        n_fail++; $display("FAIL rstload_data[%0d] got %h want 0", k, data_b);
      end
      step();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_a = 1'b1; load_a = 1'b0; blank_a = 1'b0; val_a = '0;
    rst_b = 1'b1; load_b = 1'b0; blank_b = 1'b0; val_b = '0;
    #1;
    test_reset();
    test_scan();
    test_tearing();
    test_collision();
    test_blanking();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving the number of clk cycles each digit is displayed (legal range 1..2^20).
REQ-002 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 value_in  input  16  four hex digits to display; bits 3:0 are digit 0 (rightmost).
REQ-005 load  input  1  one-cycle request to capture value_in.
REQ-006 blank_en  input  1  when high, leading-zero digits SHALL be blanked.
REQ-007 digit_data  output  4  nibble of the currently selected digit; feeds the seven-segment decoder data_in.
REQ-008 digit_sel  output  4  one-hot, active-high digit enable; bit k selects digit k.
REQ-009 frame_done  output  1  one-cycle pulse when a full 4-digit scan completes.

Function
REQ-010 A prescaler SHALL count 0..DIV-1 and wrap to 0; "tick" is the cycle in which the count equals DIV-1.
REQ-011 With DIV=1 the block SHALL assert tick every cycle.
REQ-012 A 2-bit index idx SHALL advance by 1 on each tick and wrap from 3 to 0.
REQ-013 The block SHALL keep a displayed register shadow[15:0] and a pending register with a pending flag.
REQ-014 When load=1, the block SHALL write value_in into pending and set the pending flag, overwriting any earlier unconsumed value.
REQ-015 On a tick with idx=3 (frame boundary), the block SHALL copy pending into shadow if the pending flag is set, then clear the flag.
REQ-016 If load=1 coincides with a frame-boundary tick, value_in SHALL go directly into shadow and the pending flag SHALL end cleared.
REQ-017 shadow SHALL change only at a frame boundary, so a frame never shows a mix of old and new values.
REQ-018 digit_data SHALL equal shadow[4*idx+3 : 4*idx].
REQ-019 digit_sel SHALL equal the one-hot encoding of idx, except that it SHALL be 4'b0000 when the digit is blanked.
REQ-020 Digit k (k>0) SHALL be blanked when blank_en=1 and shadow nibbles k..3 are all zero; digit 0 SHALL never be blanked.
REQ-021 digit_data, digit_sel and frame_done SHALL be driven only from registered state, with no combinational path from value_in, load or blank_en.
REQ-022 The outputs SHALL reflect a new idx on the same edge that idx updates, so there is zero extra latency after the tick edge.
REQ-023 frame_done SHALL be 1 for exactly the one cycle following a tick in which idx wrapped 3->0, and 0 otherwise.
REQ-024 blank_en SHALL be registered once, and a change SHALL take effect one cycle after it is sampled.

Reset
REQ-025 With rst=1, the block SHALL clear the prescaler, idx, shadow, pending, the pending flag and registered blank_en to 0 on the next edge.
REQ-026 After reset the outputs SHALL be digit_data=4'h0, digit_sel=4'b0001 and frame_done=0.
REQ-027 rst SHALL take priority over load and tick in the same cycle, discarding any pending value.
REQ-028 Reset mid-frame SHALL restart the scan at digit 0 with a full DIV-cycle dwell.

Verification
REQ-029 Reset test (DIV=4): assert rst and release it -> digit_sel=0001, digit_data=0, and the first change to digit_sel=0010 occurs 4 cycles after release.
REQ-030 Scan test (DIV=4): load value_in=16'h1234, then wait one frame boundary -> the next frame shows digit_data 4,3,2,1 with digit_sel 0001,0010,0100,1000, each for 4 cycles, and frame_done pulses once per 16 cycles.
REQ-031 Tearing test: load 16'hABCD while idx=1 -> the rest of the current frame keeps showing the old value, and the new value appears from the next digit 0.
REQ-032 Collision test: load 16'h5555 and then 16'h6666 within one frame, with the second load on the boundary tick -> the next frame shows 6666 and the pending flag is 0.
REQ-033 Blanking test: shadow=16'h0070 with blank_en=1 -> digit_sel is 0001, 0010, 0000, 0000; with blank_en=0 -> all four digits enabled.
REQ-034 Edge test: DIV=1 -> idx advances every cycle and frame_done pulses every 4 cycles; asserting rst together with load for one cycle -> shadow stays 0.
